// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the register-file writeback arbiter.
//   XLEN                 : datapath width
//   REG_AW               : register address width
//   WB_FIFO_DEPTH        : long-unit result buffer depth
//   STARVE_LIMIT_DEFAULT : default pipeline-win budget while results wait
//   wb_entry_t           : buffered long-unit result (destination + data)
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int XLEN                 = 32;
   localparam int REG_AW               = 5;
   localparam int WB_FIFO_DEPTH        = 2;
   localparam int STARVE_LIMIT_DEFAULT = 4;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage : wb_pkg

// File: rtl/wb_fifo2.sv
// -----------------------------------------------------------------------------
// wb_fifo2
// Two-entry strict-order buffer for long-latency unit results.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : entry to enqueue
//   pop_i        : drop the head entry (ignored when empty)
//   count_o      : number of valid entries (0..2), registered
//   head_o       : oldest entry, valid when count_o != 0
// Push and pop in the same cycle leave the count unchanged.
// -----------------------------------------------------------------------------
module wb_fifo2
   import wb_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  wb_entry_t push_data_i,
   input  logic      pop_i,
   output logic [1:0] count_o,
   output wb_entry_t head_o
);

   wb_entry_t  mem_q [WB_FIFO_DEPTH];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign do_push = push_i && (count_q != 2'd2);
   assign do_pop  = pop_i  && (count_q != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // Storage needs no reset: entries are only read while count_q says valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule : wb_fifo2

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Arbitrates the single register-file write port between the in-order
// pipeline writeback and buffered long-latency unit results.
//   clk, rst                 : clock, synchronous active-high reset
//   p_valid/p_rd/p_data      : pipeline writeback request
//   p_stall                  : pipeline request not granted this cycle
//   l_valid/l_rd/l_data      : long-unit result, transferred on l_valid&&l_ready
//   l_ready                  : buffer has room
//   rf_we/rf_waddr/rf_wdata  : registered write port, one cycle after grant
// Handshake: a long-unit result moves into the buffer on a rising edge where
// l_valid && l_ready; l_ready depends only on buffer occupancy, never on a
// same-cycle pop. The pipeline side is stall-based: its request completes on
// any cycle where p_valid && !p_stall.
// -----------------------------------------------------------------------------
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              p_valid,
   input  logic [REG_AW-1:0] p_rd,
   input  logic [XLEN-1:0]   p_data,
   output logic              p_stall,
   input  logic              l_valid,
   output logic              l_ready,
   input  logic [REG_AW-1:0] l_rd,
   input  logic [XLEN-1:0]   l_data,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata
);

   logic [1:0]        fifo_count;
   wb_entry_t         fifo_head;
   wb_entry_t         push_entry;
   logic              push;
   logic              gnt_fifo;
   logic              gnt_pipe;
   logic [3:0]        starve_q, starve_d;
   logic              rf_we_q, rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

   assign l_ready    = (fifo_count != 2'd2);
   assign push       = l_valid && l_ready;
   assign push_entry = '{rd: l_rd, data: l_data};

   wb_fifo2 u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (gnt_fifo),
      .count_o     (fifo_count),
      .head_o      (fifo_head)
   );

   // The buffer wins when the pipeline is idle, when it is full (so l_ready
   // can reopen), or once the pipeline has used up its win budget.
   assign gnt_fifo = (fifo_count != 2'd0) &&
                     (!p_valid || (fifo_count == 2'd2) ||
                      (starve_q >= 4'(STARVE_LIMIT)));
   assign gnt_pipe = p_valid && !gnt_fifo;
   assign p_stall  = p_valid && gnt_fifo;

   always_comb begin
      starve_d   = starve_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;

      if (fifo_count == 2'd0 || gnt_fifo) begin
         starve_d = 4'd0;
      end else if (gnt_pipe && starve_q != 4'd15) begin
         starve_d = starve_q + 4'd1;
      end

      // x0 writes still complete the request but never assert the enable.
      if (gnt_fifo) begin
         rf_we_d    = (fifo_head.rd != '0);
         rf_waddr_d = fifo_head.rd;
         rf_wdata_d = fifo_head.data;
      end else if (gnt_pipe) begin
         rf_we_d    = (p_rd != '0);
         rf_waddr_d = p_rd;
         rf_wdata_d = p_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q   <= 4'd0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         starve_q   <= starve_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_valid;
   logic [4:0]  p_rd;
   logic [31:0] p_data;
   logic        p_stall;
   logic        l_valid;
   logic        l_ready;
   logic [4:0]  l_rd;
   logic [31:0] l_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .p_valid  (p_valid),
      .p_rd     (p_rd),
      .p_data   (p_data),
      .p_stall  (p_stall),
      .l_valid  (l_valid),
      .l_ready  (l_ready),
      .l_rd     (l_rd),
      .l_data   (l_data),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata)
   );

   // Inputs change at posedge+1; combinational outputs are sampled 1 time
   // unit later, registered outputs right after the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p_valid = 1'b0; p_rd = '0; p_data = '0;
      l_valid = 1'b0; l_rd = '0; l_data = '0;
   endtask

   // Checks a registered write (or its absence when exp_we==0).
   task automatic chk_write(input string name, input logic exp_we,
                            input logic [4:0] exp_a, input logic [31:0] exp_d);
      tests_run++;
      if (rf_we !== exp_we || (exp_we && (rf_waddr !== exp_a || rf_wdata !== exp_d))) begin
         fails++;
         $display("FAIL %s: got we=%b a=%0d d=%h, expected we=%b a=%0d d=%h",
                  name, rf_we, rf_waddr, rf_wdata, exp_we, exp_a, exp_d);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      tests_run++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
         fails++;
         $display("FAIL reset_outputs: got we=%b a=%0d d=%h, expected 0/0/0",
                  rf_we, rf_waddr, rf_wdata);
      end
      tests_run++;
      if (l_ready !== 1'b1 || p_stall !== 1'b0) begin
         fails++;
         $display("FAIL reset_handshake: got l_ready=%b p_stall=%b, expected 1/0",
                  l_ready, p_stall);
      end
   endtask

   task automatic test_pipeline_only();
      p_valid = 1'b1; p_rd = 5'd5; p_data = 32'hAAAA_AAAA;
      #1;
      tests_run++;
      if (p_stall !== 1'b0) begin
         fails++;
         $display("FAIL pipe_stall: got %b, expected 0", p_stall);
      end
      tick();
      p_valid = 1'b0;
      chk_write("pipe_write", 1'b1, 5'd5, 32'hAAAA_AAAA);
      tick();
      chk_write("pipe_idle", 1'b0, 5'd0, 32'd0);
      tests_run++;
      if (rf_waddr !== 5'd5 || rf_wdata !== 32'hAAAA_AAAA) begin
         fails++;
         $display("FAIL pipe_hold: got a=%0d d=%h, expected a=5 d=aaaaaaaa",
                  rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_long_only();
      l_valid = 1'b1; l_rd = 5'd7; l_data = 32'hBBBB_BBBB;
      #1;
      tests_run++;
      if (l_ready !== 1'b1) begin
         fails++;
         $display("FAIL long_ready: got %b, expected 1", l_ready);
      end
      tick();
      l_valid = 1'b0;
      chk_write("long_no_same_cycle", 1'b0, 5'd0, 32'd0);
      tick();
      chk_write("long_write", 1'b1, 5'd7, 32'hBBBB_BBBB);
      tick();
      chk_write("long_idle", 1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_starvation();
      l_valid = 1'b1; l_rd = 5'd3; l_data = 32'h3333_3333;
      tick();
      l_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         p_valid = 1'b1; p_rd = 5'(8 + k); p_data = 32'h1000 + k;
         #1;
         tests_run++;
         if (p_stall !== 1'b0) begin
            fails++;
            $display("FAIL starve_pipe_stall%0d: got %b, expected 0", k, p_stall);
         end
         tick();
         chk_write($sformatf("starve_pipe_write%0d", k), 1'b1, 5'(8 + k), 32'h1000 + k);
      end
      p_rd = 5'd12; p_data = 32'h1004;
      #1;
      tests_run++;
      if (p_stall !== 1'b1) begin
         fails++;
         $display("FAIL starve_stall: got %b, expected 1", p_stall);
      end
      tick();
      chk_write("starve_fifo_write", 1'b1, 5'd3, 32'h3333_3333);
      #1;
      tests_run++;
      if (p_stall !== 1'b0) begin
         fails++;
         $display("FAIL starve_resume_stall: got %b, expected 0", p_stall);
      end
      tick();
      p_valid = 1'b0;
      chk_write("starve_resume_write", 1'b1, 5'd12, 32'h1004);
      tick();
   endtask

   task automatic test_full_fifo();
      p_valid = 1'b1; p_rd = 5'd20; p_data = 32'h2020;
      l_valid = 1'b1; l_rd = 5'd1; l_data = 32'h1111_1111;
      tick();
      chk_write("full_pipe0", 1'b1, 5'd20, 32'h2020);
      p_rd = 5'd21; p_data = 32'h2121;
      l_rd = 5'd2; l_data = 32'h2222_2222;
      #1;
      tests_run++;
      if (l_ready !== 1'b1 || p_stall !== 1'b0) begin
         fails++;
         $display("FAIL full_second_push: got l_ready=%b p_stall=%b, expected 1/0",
                  l_ready, p_stall);
      end
      tick();
      chk_write("full_pipe1", 1'b1, 5'd21, 32'h2121);
      l_valid = 1'b0;
      p_rd = 5'd22; p_data = 32'h2222;
      #1;
      tests_run++;
      if (l_ready !== 1'b0 || p_stall !== 1'b1) begin
         fails++;
         $display("FAIL full_state: got l_ready=%b p_stall=%b, expected 0/1",
                  l_ready, p_stall);
      end
      tick();
      chk_write("full_first_rd1", 1'b1, 5'd1, 32'h1111_1111);
      tests_run++;
      if (l_ready !== 1'b1 || p_stall !== 1'b0) begin
         fails++;
         $display("FAIL full_after_pop: got l_ready=%b p_stall=%b, expected 1/0",
                  l_ready, p_stall);
      end
      tick();
      chk_write("full_pipe2", 1'b1, 5'd22, 32'h2222);
      p_valid = 1'b0;
      tick();
      chk_write("full_second_rd2", 1'b1, 5'd2, 32'h2222_2222);
      tick();
      chk_write("full_drained", 1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_rd_zero();
      l_valid = 1'b1; l_rd = 5'd0; l_data = 32'hDEAD_BEEF;
      tick();
      l_valid = 1'b0;
      tick();
      chk_write("rd0_no_write", 1'b0, 5'd0, 32'd0);
      // Buffer should be empty again: one push must leave room for another.
      l_valid = 1'b1; l_rd = 5'd9; l_data = 32'h9999_9999;
      p_valid = 1'b1; p_rd = 5'd14; p_data = 32'h1414;
      tick();
      chk_write("rd0_no_dup", 1'b1, 5'd14, 32'h1414);
      l_valid = 1'b0; p_valid = 1'b0;
      #1;
      tests_run++;
      if (l_ready !== 1'b1) begin
         fails++;
         $display("FAIL rd0_count: got l_ready=%b, expected 1", l_ready);
      end
      tick();
      chk_write("rd0_next_entry", 1'b1, 5'd9, 32'h9999_9999);
      tick();
   endtask

   task automatic test_back_to_back();
      l_valid = 1'b1; l_rd = 5'd11; l_data = 32'hB0B0_0011;
      tick();
      chk_write("b2b_latency", 1'b0, 5'd0, 32'd0);
      l_rd = 5'd12; l_data = 32'hB0B0_0012;
      tick();
      chk_write("b2b_w11", 1'b1, 5'd11, 32'hB0B0_0011);
      l_rd = 5'd13; l_data = 32'hB0B0_0013;
      #1;
      tests_run++;
      if (l_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_count_steady: got l_ready=%b, expected 1", l_ready);
      end
      tick();
      chk_write("b2b_w12", 1'b1, 5'd12, 32'hB0B0_0012);
      l_valid = 1'b0;
      tick();
      chk_write("b2b_w13", 1'b1, 5'd13, 32'hB0B0_0013);
      tick();
      chk_write("b2b_idle", 1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_reset_mid();
      p_valid = 1'b1; p_rd = 5'd25; p_data = 32'h2525;
      l_valid = 1'b1; l_rd = 5'd4; l_data = 32'h4444_4444;
      tick();
      p_rd = 5'd26; p_data = 32'h2626;
      l_rd = 5'd5; l_data = 32'h5555_5555;
      tick();
      idle_inputs();
      #1;
      tests_run++;
      if (l_ready !== 1'b0) begin
         fails++;
         $display("FAIL mid_full_before_rst: got l_ready=%b, expected 0", l_ready);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || l_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_rst_state: got we=%b a=%0d d=%h l_ready=%b, expected 0/0/0/1",
                  rf_we, rf_waddr, rf_wdata, l_ready);
      end
      tick();
      chk_write("mid_no_write1", 1'b0, 5'd0, 32'd0);
      tick();
      chk_write("mid_no_write2", 1'b0, 5'd0, 32'd0);
      p_valid = 1'b1; p_rd = 5'd27; p_data = 32'h2727;
      #1;
      tests_run++;
      if (p_stall !== 1'b0) begin
         fails++;
         $display("FAIL mid_pipe_free: got p_stall=%b, expected 0", p_stall);
      end
      tick();
      chk_write("mid_pipe_write", 1'b1, 5'd27, 32'h2727);
      idle_inputs();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_pipeline_only();
      test_long_only();
      test_starvation();
      test_full_fifo();
      test_rd_zero();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule : tb_wb_arbiter
